// File: rtl/mem_write_buffer.sv
// ---------------------------------------------------------------------------
// mem_write_buffer
//   Posted-store FIFO between the write-through cache hierarchy and the
//   unified RAM. CPU word stores are buffered so the pipeline never waits on
//   RAM writes. Entries drain to RAM whenever the port is not serving a
//   fill read. Fill reads return RAM data with pending stores byte-merged on
//   top (youngest wins), so a fill never observes stale RAM contents.
//
// Ports
//   clk, rst                 clock (rising edge), async active-high reset
//   wr_valid/addr/data/byte_en, wr_ready    store request channel
//   rd_req, rd_addr, rd_data, rd_ready      combinational fill-read channel
//   ram_addr, ram_w_data, ram_we, ram_byte_en, ram_r_data   RAM port
//   flush                    drain request (informational; drain is eager)
//   empty, count             occupancy status
// ---------------------------------------------------------------------------
module mem_write_buffer #(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 32,
   parameter int DEPTH        = 4,
   parameter int STARVE_LIMIT = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         wr_valid,
   input  logic [ADDR_WIDTH-1:0]        wr_addr,
   input  logic [DATA_WIDTH-1:0]        wr_data,
   input  logic [DATA_WIDTH/8-1:0]      wr_byte_en,
   output logic                         wr_ready,
   input  logic                         rd_req,
   input  logic [ADDR_WIDTH-1:0]        rd_addr,
   output logic [DATA_WIDTH-1:0]        rd_data,
   output logic                         rd_ready,
   output logic [ADDR_WIDTH-1:0]        ram_addr,
   output logic [DATA_WIDTH-1:0]        ram_w_data,
   output logic                         ram_we,
   output logic [DATA_WIDTH/8-1:0]      ram_byte_en,
   input  logic [DATA_WIDTH-1:0]        ram_r_data,
   input  logic                         flush,
   output logic                         empty,
   output logic [$clog2(DEPTH):0]       count
);

   localparam int BE_W  = DATA_WIDTH / 8;
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int WA_W  = ADDR_WIDTH - 2;
   localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

   localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(DEPTH);
   localparam logic [SC_W-1:0]  STARVE_MAX = SC_W'(STARVE_LIMIT);

   // Overlay the enabled byte lanes of new_word onto old_word.
   function automatic logic [DATA_WIDTH-1:0] merge_bytes(
      input logic [DATA_WIDTH-1:0] old_word,
      input logic [DATA_WIDTH-1:0] new_word,
      input logic [BE_W-1:0]       be
   );
      logic [DATA_WIDTH-1:0] res;
      res = old_word;
      for (int b = 0; b < BE_W; b++) begin
         if (be[b]) begin
            res[8*b +: 8] = new_word[8*b +: 8];
         end else begin
            res[8*b +: 8] = old_word[8*b +: 8];
         end
      end
      return res;
   endfunction

   // Entry storage; an entry is valid when it lies within count_r of head_r.
   logic [WA_W-1:0]       ent_addr_r [DEPTH];
   logic [DATA_WIDTH-1:0] ent_data_r [DEPTH];
   logic [BE_W-1:0]       ent_be_r   [DEPTH];

   logic [PTR_W-1:0] head_r;
   logic [PTR_W-1:0] tail_r;
   logic [CNT_W-1:0] count_r;
   logic [SC_W-1:0]  starve_r;

   logic [PTR_W-1:0]      youngest_s;
   logic [WA_W-1:0]       wr_word_s;
   logic [WA_W-1:0]       rd_word_s;
   logic                  full_s;
   logic                  force_drain_s;
   logic                  rd_grant_s;
   logic                  drain_s;
   logic                  young_match_s;
   logic                  coalesce_s;
   logic                  wr_take_s;
   logic                  push_s;
   logic [DATA_WIDTH-1:0] merged_s;

   // Address low bits are ignored by design; flush needs no action because
   // the buffer already drains whenever the RAM port is free.
   logic unused_s;
   assign unused_s = ^{wr_addr[1:0], rd_addr[1:0], flush};

   assign youngest_s    = tail_r - PTR_W'(1);
   assign wr_word_s     = wr_addr[ADDR_WIDTH-1:2];
   assign rd_word_s     = rd_addr[ADDR_WIDTH-1:2];
   assign full_s        = (count_r == FULL_CNT);
   assign force_drain_s = full_s && (starve_r == STARVE_MAX);
   assign rd_grant_s    = rd_req && !force_drain_s;
   assign drain_s       = !rd_grant_s && (count_r != CNT_W'(0));
   assign young_match_s = (count_r != CNT_W'(0)) && (ent_addr_r[youngest_s] == wr_word_s);

   // When full, the youngest entry can never be the head (DEPTH >= 2), so
   // wr_ready depends on registered state only and never on rd_req.
   assign wr_ready   = !full_s || young_match_s;
   // Coalescing into the sole entry while it is being written out would lose
   // the new bytes, so that case becomes a fresh push instead.
   assign coalesce_s = young_match_s && !(drain_s && (count_r == CNT_W'(1)));
   assign wr_take_s  = wr_valid && wr_ready && (wr_byte_en != BE_W'(0));
   assign push_s     = wr_take_s && !coalesce_s;

   assign rd_ready = rd_grant_s;
   assign empty    = (count_r == CNT_W'(0));
   assign count    = count_r;

   // Read merge: RAM data overlaid by matching entries, oldest to youngest.
   always_comb begin
      merged_s = ram_r_data;
      for (int i = 0; i < DEPTH; i++) begin
         if ((CNT_W'(i) < count_r) && (ent_addr_r[head_r + PTR_W'(i)] == rd_word_s)) begin
            merged_s = merge_bytes(merged_s, ent_data_r[head_r + PTR_W'(i)],
                                   ent_be_r[head_r + PTR_W'(i)]);
         end else begin
            merged_s = merged_s;
         end
      end
   end

   // RAM port mux: granted read, else drain of the head entry, else idle.
   always_comb begin
      ram_addr    = '0;
      ram_w_data  = '0;
      ram_we      = 1'b0;
      ram_byte_en = '0;
      rd_data     = '0;
      if (rd_grant_s) begin
         ram_addr = {rd_word_s, 2'b00};
         rd_data  = merged_s;
      end else if (drain_s) begin
         ram_we      = 1'b1;
         ram_addr    = {ent_addr_r[head_r], 2'b00};
         ram_w_data  = ent_data_r[head_r];
         ram_byte_en = ent_be_r[head_r];
      end else begin
         ram_addr    = '0;
         ram_byte_en = '0;
      end
   end

   // Pointer, occupancy and starvation bookkeeping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_r   <= '0;
         tail_r   <= '0;
         count_r  <= '0;
         starve_r <= '0;
      end else begin
         if (drain_s) begin
            head_r <= head_r + PTR_W'(1);
         end
         if (push_s) begin
            tail_r <= tail_r + PTR_W'(1);
         end
         case ({push_s, drain_s})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
         // Counts consecutive granted reads that find the buffer full.
         if (drain_s || !full_s) begin
            starve_r <= '0;
         end else if (rd_grant_s && (starve_r != STARVE_MAX)) begin
            starve_r <= starve_r + SC_W'(1);
         end else begin
            starve_r <= starve_r;
         end
      end
   end

   // Entry payload: push at tail or byte-merge into the youngest entry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            ent_addr_r[i] <= '0;
            ent_data_r[i] <= '0;
            ent_be_r[i]   <= '0;
         end
      end else if (push_s) begin
         ent_addr_r[tail_r] <= wr_word_s;
         ent_data_r[tail_r] <= wr_data;
         ent_be_r[tail_r]   <= wr_byte_en;
      end else if (wr_take_s) begin
         ent_data_r[youngest_s] <= merge_bytes(ent_data_r[youngest_s], wr_data, wr_byte_en);
         ent_be_r[youngest_s]   <= ent_be_r[youngest_s] | wr_byte_en;
      end
   end

endmodule

// File: tb/tb_mem_write_buffer.sv
module tb_mem_write_buffer;

   logic        clk;
   logic        rst;
   logic        wr_valid;
   logic [31:0] wr_addr;
   logic [31:0] wr_data;
   logic [3:0]  wr_byte_en;
   logic        wr_ready;
   logic        rd_req;
   logic [31:0] rd_addr;
   logic [31:0] rd_data;
   logic        rd_ready;
   logic [31:0] ram_addr;
   logic [31:0] ram_w_data;
   logic        ram_we;
   logic [3:0]  ram_byte_en;
   logic [31:0] ram_r_data;
   logic        flush;
   logic        empty;
   logic [2:0]  count;

   mem_write_buffer dut (
      .clk(clk), .rst(rst),
      .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_byte_en(wr_byte_en), .wr_ready(wr_ready),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_ready(rd_ready),
      .ram_addr(ram_addr), .ram_w_data(ram_w_data), .ram_we(ram_we),
      .ram_byte_en(ram_byte_en), .ram_r_data(ram_r_data),
      .flush(flush), .empty(empty), .count(count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] be);
      logic [31:0] r;
      r = o;
      for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
      return r;
   endfunction

   // Environment RAM, written only by the DUT's RAM port.
   logic [31:0] ram_mem [0:1023] = '{default: 32'h0};
   int          ram_wr_cnt = 0;
   assign ram_r_data = ram_mem[ram_addr[11:2]];
   always @(posedge clk) begin
      if (ram_we) begin
         ram_mem[ram_addr[11:2]] <= bmerge(ram_mem[ram_addr[11:2]], ram_w_data, ram_byte_en);
         ram_wr_cnt <= ram_wr_cnt + 1;
      end
   end

   // Reference model: memory image plus an ordered list of pending stores.
   typedef struct packed {
      logic [29:0] wa;
      logic [31:0] d;
      logic [3:0]  be;
   } ent_t;
   ent_t        model_q[$];
   logic [31:0] model_mem [0:1023] = '{default: 32'h0};
   int          model_starve = 0;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [31:0] read_view(input logic [29:0] wa);
      logic [31:0] r;
      r = model_mem[wa[9:0]];
      foreach (model_q[i]) if (model_q[i].wa == wa) r = bmerge(r, model_q[i].d, model_q[i].be);
      return r;
   endfunction

   task automatic drive(input logic wv, input logic [31:0] wa, input logic [31:0] wd,
                        input logic [3:0] wbe, input logic rq, input logic [31:0] ra);
      wr_valid = wv; wr_addr = wa; wr_data = wd; wr_byte_en = wbe;
      rd_req = rq; rd_addr = ra;
   endtask

   // One clock: check all outputs against the model, then advance the model.
   task automatic cycle();
      int          n;
      bit          full, e_rd, e_dr, e_wrdy, acc, coal;
      logic [29:0] wa_w, wa_r;
      logic [31:0] wd;
      logic [3:0]  wbe;
      ent_t        e;
      #1;
      n      = model_q.size();
      full   = (n == 4);
      e_rd   = rd_req && !(full && model_starve == 8);
      e_dr   = !e_rd && (n != 0);
      wa_w   = wr_addr[31:2];
      wa_r   = rd_addr[31:2];
      wd     = wr_data;
      wbe    = wr_byte_en;
      e_wrdy = !full || (n > 0 && model_q[n-1].wa == wa_w);
      chk("rd_ready", 64'(rd_ready), 64'(e_rd));
      chk("wr_ready", 64'(wr_ready), 64'(e_wrdy));
      chk("count", 64'(count), 64'(n));
      chk("empty", 64'(empty), 64'(n == 0));
      chk("ram_we", 64'(ram_we), 64'(e_dr));
      if (e_rd) begin
         chk("rd_data", 64'(rd_data), 64'(read_view(wa_r)));
         chk("ram_addr_rd", 64'(ram_addr), 64'({wa_r, 2'b00}));
      end else if (e_dr) begin
         chk("ram_addr_wr", 64'(ram_addr), 64'({model_q[0].wa, 2'b00}));
         chk("ram_w_data", 64'(ram_w_data), 64'(model_q[0].d));
         chk("ram_byte_en", 64'(ram_byte_en), 64'(model_q[0].be));
      end else begin
         chk("ram_addr_idle", 64'(ram_addr), 64'h0);
         chk("ram_be_idle", 64'(ram_byte_en), 64'h0);
      end
      if (!rd_req) chk("rd_data_idle", 64'(rd_data), 64'h0);
      acc  = wr_valid && e_wrdy && (wbe != 4'h0);
      coal = acc && n > 0 && model_q[n-1].wa == wa_w && !(e_dr && n == 1);
      @(posedge clk);
      if (coal) begin
         e = model_q[n-1];
         e.d = bmerge(e.d, wd, wbe);
         e.be = e.be | wbe;
         model_q[n-1] = e;
      end
      if (e_dr) begin
         model_mem[model_q[0].wa[9:0]] = bmerge(model_mem[model_q[0].wa[9:0]], model_q[0].d, model_q[0].be);
         void'(model_q.pop_front());
      end
      if (acc && !coal) model_q.push_back('{wa: wa_w, d: wd, be: wbe});
      if (e_dr || !full) model_starve = 0;
      else if (e_rd && model_starve < 8) model_starve++;
      @(negedge clk);
   endtask

   task automatic drain_all();
      int budget;
      budget = 0;
      drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0);
      while (model_q.size() != 0 && budget < 40) begin
         cycle();
         budget++;
      end
      chk("drain_timeout", 64'(model_q.size()), 64'h0);
   endtask

   initial begin
      int wc0;
      rst = 1'b1;
      flush = 1'b0;
      drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0);
      #2;
      chk("rst_count", 64'(count), 64'h0);
      chk("rst_empty", 64'(empty), 64'h1);
      chk("rst_wr_ready", 64'(wr_ready), 64'h1);
      chk("rst_ram_we", 64'(ram_we), 64'h0);
      chk("rst_ram_be", 64'(ram_byte_en), 64'h0);
      chk("rst_rd_ready", 64'(rd_ready), 64'h0);
      chk("rst_rd_data", 64'(rd_data), 64'h0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // 1: single store drains on the following cycle.
      drive(1'b1, 32'h100, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0);
      cycle();
      drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0);
      #1;
      chk("t1_we", 64'(ram_we), 64'h1);
      chk("t1_addr", 64'(ram_addr), 64'h100);
      chk("t1_cnt1", 64'(count), 64'h1);
      cycle();
      chk("t1_cnt0", 64'(count), 64'h0);
      chk("t1_mem", 64'(ram_mem[10'h40]), 64'hDEADBEEF);

      // 2: second store to same word coalesces while reads hold the port.
      drive(1'b1, 32'h200, 32'h11223344, 4'hF, 1'b1, 32'h0);
      cycle();
      drive(1'b1, 32'h200, 32'h000000AA, 4'h1, 1'b1, 32'h0);
      #1;
      chk("t2_wr_ready", 64'(wr_ready), 64'h1);
      cycle();
      drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h0);
      #1;
      chk("t2_cnt", 64'(count), 64'h1);
      cycle();
      wc0 = ram_wr_cnt;
      drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0);
      #1;
      chk("t2_wdata", 64'(ram_w_data), 64'h112233AA);
      cycle();
      chk("t2_writes", 64'(ram_wr_cnt - wc0), 64'h1);
      chk("t2_mem", 64'(ram_mem[10'h80]), 64'h112233AA);

      // 3: read merges pending partial store over RAM contents.
      drive(1'b1, 32'h300, 32'hFFFFFFFF, 4'hF, 1'b0, 32'h0);
      cycle();
      drain_all();
      drive(1'b1, 32'h300, 32'h00001234, 4'h3, 1'b1, 32'h0);
      cycle();
      drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h300);
      #1;
      chk("t3_rd_data", 64'(rd_data), 64'hFFFF1234);
      chk("t3_no_drain", 64'(ram_we), 64'h0);
      cycle();
      drain_all();

      // 4+5: fill, blocked store, 8 granted reads, then a forced drain.
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, 32'h500 + 32'(4 * k), 32'hA0000000 + 32'(k), 4'hF, 1'b1, 32'h0);
         cycle();
      end
      drive(1'b1, 32'h400, 32'h44444444, 4'hF, 1'b1, 32'h0);
      for (int k = 0; k < 8; k++) begin
         #1;
         chk("t5_rd_ready", 64'(rd_ready), 64'h1);
         chk("t4_blocked", 64'(wr_ready), 64'h0);
         cycle();
      end
      #1;
      chk("t5_forced", 64'(rd_ready), 64'h0);
      chk("t5_drain_we", 64'(ram_we), 64'h1);
      chk("t5_drain_addr", 64'(ram_addr), 64'h500);
      chk("t4_still_blocked", 64'(wr_ready), 64'h0);
      cycle();
      #1;
      chk("t4_ready_after", 64'(wr_ready), 64'h1);
      chk("t4_cnt3", 64'(count), 64'h3);
      cycle();
      drain_all();

      // 6: async reset in the middle of draining.
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, 32'h600 + 32'(4 * k), 32'hC0000000 + 32'(k), 4'hF, 1'b1, 32'h0);
         cycle();
      end
      drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0);
      #1;
      chk("t6_pre_we", 64'(ram_we), 64'h1);
      chk("t6_pre_cnt", 64'(count), 64'h3);
      #1 rst = 1'b1;
      #1;
      chk("t6_cnt", 64'(count), 64'h0);
      chk("t6_empty", 64'(empty), 64'h1);
      chk("t6_we", 64'(ram_we), 64'h0);
      model_q.delete();
      model_starve = 0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("t6_mem_untouched", 64'(ram_mem[10'h180]), 64'h0);

      // Randomized traffic over a few words to hit coalescing and starvation.
      for (int i = 0; i < 600; i++) begin
         int p_rd;
         p_rd = ((i % 200) < 60) ? 100 : 40;
         drive(($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0,
               32'($urandom_range(0, 7) * 4 + $urandom_range(0, 3)),
               32'($urandom),
               4'($urandom_range(0, 15)),
               (32'($urandom_range(0, 99)) < 32'(p_rd)) ? 1'b1 : 1'b0,
               32'($urandom_range(0, 7) * 4 + $urandom_range(0, 3)));
         cycle();
      end
      drain_all();
      for (int w = 0; w < 8; w++) chk("final_mem", 64'(ram_mem[w]), 64'(model_mem[w]));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
